// File: rtl/serial_frame_pkg.sv
// Shared types and defaults for the serial frame arbiter and its shift register.
// The winner function holds the round-robin tie-break so the FSM stays readable.
package serial_frame_pkg;

  localparam int NBITS_DEFAULT = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} frame_state_t;
  typedef enum logic {GRANT_A, GRANT_B} grant_t;

  // On a tie the requester that was not served last wins.
  function automatic grant_t pick_winner(input logic req_a, input logic req_b, input grant_t last);
    if (req_a && req_b) return (last == GRANT_A) ? GRANT_B : GRANT_A;
    return req_a ? GRANT_A : GRANT_B;
  endfunction

endpackage

// File: rtl/frame_shreg.sv
// Parallel-load / serial-shift register: new bits enter at the MSB, the LSB leaves first.
// A load takes priority over a shift in the same cycle.
module frame_shreg
  import serial_frame_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [NBITS-1:0] din,
  input  logic             ser_in,
  output logic [NBITS-1:0] q
);

  logic [NBITS-1:0] r_q;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= din;
    end else if (shift) begin
      r_q <= {ser_in, r_q[NBITS-1:1]};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/serial_frame_arbiter.sv
// Round-robin arbiter that lends one shift register to requesters A and B and
// runs a full-duplex frame: transmit LSB-first while receiving into the MSB.
module serial_frame_arbiter
  import serial_frame_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT,
  parameter int CNT_W = $clog2(NBITS)
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             req_a,
  input  logic [NBITS-1:0] data_a,
  input  logic             req_b,
  input  logic [NBITS-1:0] data_b,
  input  logic             abort,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             grant_a,
  output logic             grant_b,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] rx_data
);

  frame_state_t     r_state;
  grant_t           r_last_grant;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_grant_a;
  logic             r_grant_b;
  logic             r_done;
  logic [NBITS-1:0] r_rx_data;

  grant_t           w_winner;
  logic             w_any_req;
  logic             w_load;
  logic             w_shift;
  logic [NBITS-1:0] w_load_data;
  logic [NBITS-1:0] w_q;

  assign w_any_req   = req_a | req_b;
  assign w_winner    = pick_winner(req_a, req_b, r_last_grant);
  assign w_load_data = (w_winner == GRANT_A) ? data_a : data_b;
  assign w_load      = (r_state == IDLE) && w_any_req;
  // An aborted edge leaves the partial word untouched.
  assign w_shift     = (r_state == SHIFT) && !abort;

  frame_shreg #(
    .NBITS (NBITS)
  ) u_shreg (
    .clk_2  (clk_2),
    .reset  (reset),
    .load   (w_load),
    .shift  (w_shift),
    .din    (w_load_data),
    .ser_in (ser_in),
    .q      (w_q)
  );

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_B;
      r_bit_cnt    <= '0;
      r_grant_a    <= 1'b0;
      r_grant_b    <= 1'b0;
      r_done       <= 1'b0;
      r_rx_data    <= '0;
    end else begin
      r_grant_a <= 1'b0;
      r_grant_b <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_last_grant <= w_winner;
            r_grant_a    <= (w_winner == GRANT_A);
            r_grant_b    <= (w_winner == GRANT_B);
            r_bit_cnt    <= '0;
            r_state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            r_state <= IDLE;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == CNT_W'(NBITS - 1)) begin
              r_rx_data <= {ser_in, w_q[NBITS-1:1]};
              r_done    <= 1'b1;
              r_state   <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ser_out   = w_q[0];
  assign ser_valid = (r_state == SHIFT);
  assign busy      = (r_state != IDLE);
  assign grant_a   = r_grant_a;
  assign grant_b   = r_grant_b;
  assign done      = r_done;
  assign rx_data   = r_rx_data;

endmodule

// File: tb/tb_serial_frame_arbiter.sv
// Scenario bench for serial_frame_arbiter (NBITS=4): expected grants, transmitted
// words and received words are queued as stimulus is set up and popped per frame.
module tb_serial_frame_arbiter;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0;
  logic [3:0] data_a = '0;
  logic       req_b = 1'b0;
  logic [3:0] data_b = '0;
  logic       abort = 1'b0;
  logic       ser_in = 1'b0;
  logic       ser_out, ser_valid, grant_a, grant_b, busy, done;
  logic [3:0] rx_data;

  int total = 0;
  int bad = 0;

  logic [1:0] exp_grant_q[$];
  logic [3:0] exp_tx_q[$];
  logic [3:0] exp_rx_q[$];

  localparam logic [1:0] G_A = 2'b01;
  localparam logic [1:0] G_B = 2'b10;

  serial_frame_arbiter #(.NBITS(4)) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .req_a     (req_a),
    .data_a    (data_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .abort     (abort),
    .ser_in    (ser_in),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .grant_a   (grant_a),
    .grant_b   (grant_b),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data)
  );

  always #5 clk_2 = ~clk_2;

  // Waits (bounded) for a grant, then follows the frame until busy drops,
  // driving ser_in per SHIFT cycle. Returns at the negedge of the first IDLE cycle.
  task automatic capture_frame(input logic [3:0] rx_bits, input bit hold_req,
                               input int raise_b_at, input int abort_at,
                               output logic [1:0] g, output logic [3:0] tx,
                               output int nvalid, output int ngrant,
                               output logic done_seen, output logic [3:0] rx_at_done,
                               output int nbusy, output int nwait, output bit timeout);
    g = 2'b00; tx = '0; nvalid = 0; ngrant = 0; done_seen = 1'b0;
    rx_at_done = '0; nbusy = 0; nwait = 0; timeout = 1'b0;
    do begin
      @(negedge clk_2);
      nwait++;
    end while (!(grant_a || grant_b) && nwait < 40);
    if (!(grant_a || grant_b)) begin
      timeout = 1'b1;
      return;
    end
    g = {grant_b, grant_a};
    if (!hold_req) begin
      req_a = 1'b0;
      req_b = 1'b0;
    end
    while (busy && nbusy < 40) begin
      abort = 1'b0;
      nbusy++;
      if (grant_a || grant_b) ngrant++;
      if (done) begin
        done_seen  = 1'b1;
        rx_at_done = rx_data;
      end
      if (ser_valid && nvalid < 4) begin
        tx[nvalid] = ser_out;
        ser_in = rx_bits[nvalid];
        if (nvalid == raise_b_at) req_b = 1'b1;
        if (nvalid == abort_at) abort = 1'b1;
        nvalid++;
      end
      @(negedge clk_2);
    end
    abort = 1'b0;
    if (busy) timeout = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++;
    if ({busy, ser_valid, ser_out, grant_a, grant_b, done, rx_data} !== 10'b0) begin
      $display("FAIL reset_outputs: got %b want 0", {busy, ser_valid, ser_out, grant_a, grant_b, done, rx_data});
      bad++;
    end
    repeat (2) @(negedge clk_2);
    reset = 1'b0;
    repeat (3) @(negedge clk_2);
    total++;
    if ({busy, ser_valid, grant_a, grant_b} !== 4'b0) begin
      $display("FAIL reset_idle_hold: got %b want 0000", {busy, ser_valid, grant_a, grant_b});
      bad++;
    end
    $display("reset: outputs zero, idle held with no request");
  endtask

  task automatic test_tx_basic();
    logic [1:0] g; logic [3:0] tx; int nvalid, ngrant, nbusy, nwait;
    logic done_seen; logic [3:0] rxd; bit to;
    data_a = 4'b1011; req_a = 1'b1;
    exp_grant_q.push_back(G_A); exp_tx_q.push_back(4'b1011); exp_rx_q.push_back(4'b0000);
    capture_frame(4'b0000, 1'b0, -1, -1, g, tx, nvalid, ngrant, done_seen, rxd, nbusy, nwait, to);
    total++;
    if (to) begin $display("FAIL tx_basic timeout: got timeout want frame"); bad++; end
    total++;
    if (g !== exp_grant_q.pop_front()) begin $display("FAIL tx_basic grant: got %b want 01", g); bad++; end
    total++;
    if (tx !== exp_tx_q.pop_front()) begin $display("FAIL tx_basic tx: got %b want 1011", tx); bad++; end
    total++;
    if (ngrant !== 1 || nvalid !== 4) begin
      $display("FAIL tx_basic pulse/valid: got grant=%0d valid=%0d want 1/4", ngrant, nvalid); bad++;
    end
    total++;
    if (nbusy !== 5 || done_seen !== 1'b1) begin
      $display("FAIL tx_basic busy/done: got busy=%0d done=%b want 5/1", nbusy, done_seen); bad++;
    end
    total++;
    if (rxd !== exp_rx_q.pop_front()) begin $display("FAIL tx_basic rx: got %b want 0000", rxd); bad++; end
    $display("tx_basic: grant=%b tx=%b busy=%0d rx=%b", g, tx, nbusy, rxd);
  endtask

  task automatic test_round_robin();
    logic [1:0] g; logic [3:0] tx; int nvalid, ngrant, nbusy, nwait;
    logic done_seen; logic [3:0] rxd; bit to;
    @(negedge clk_2);
    reset = 1'b1;
    data_a = 4'hA; data_b = 4'h5; req_a = 1'b1; req_b = 1'b1;
    @(negedge clk_2);
    reset = 1'b0;
    exp_grant_q.push_back(G_A); exp_tx_q.push_back(4'hA);
    exp_grant_q.push_back(G_B); exp_tx_q.push_back(4'h5);
    exp_grant_q.push_back(G_A); exp_tx_q.push_back(4'hA);
    for (int k = 0; k < 3; k++) begin
      capture_frame(4'b0000, (k < 2), -1, -1, g, tx, nvalid, ngrant, done_seen, rxd, nbusy, nwait, to);
      total++;
      if (to) begin $display("FAIL rr timeout frame %0d: got timeout want frame", k); bad++; end
      total++;
      if (g !== exp_grant_q.pop_front()) begin $display("FAIL rr grant frame %0d: got %b", k, g); bad++; end
      total++;
      if (tx !== exp_tx_q.pop_front()) begin $display("FAIL rr tx frame %0d: got %b", k, tx); bad++; end
      // Grant spacing of 6 = one wait cycle from IDLE plus 5 busy cycles.
      total++;
      if (nwait !== 1 || nbusy !== 5) begin
        $display("FAIL rr spacing frame %0d: got wait=%0d busy=%0d want 1/5", k, nwait, nbusy); bad++;
      end
      $display("round_robin frame %0d: grant=%b tx=%b wait=%0d busy=%0d", k, g, tx, nwait, nbusy);
    end
  endtask

  task automatic test_late_req();
    logic [1:0] g; logic [3:0] tx; int nvalid, ngrant, nbusy, nwait;
    logic done_seen; logic [3:0] rxd; bit to;
    data_a = 4'h3; data_b = 4'hE; req_a = 1'b1;
    exp_grant_q.push_back(G_A); exp_grant_q.push_back(G_B); exp_tx_q.push_back(4'hE);
    capture_frame(4'b0000, 1'b0, 1, -1, g, tx, nvalid, ngrant, done_seen, rxd, nbusy, nwait, to);
    total++;
    if (to || g !== exp_grant_q.pop_front() || ngrant !== 1) begin
      $display("FAIL late_req first: got grant=%b pulses=%0d to=%0d want 01/1/0", g, ngrant, to); bad++;
    end
    capture_frame(4'b0000, 1'b0, -1, -1, g, tx, nvalid, ngrant, done_seen, rxd, nbusy, nwait, to);
    total++;
    if (to || g !== exp_grant_q.pop_front() || nwait !== 1) begin
      $display("FAIL late_req second: got grant=%b wait=%0d to=%0d want 10/1/0", g, nwait, to); bad++;
    end
    total++;
    if (tx !== exp_tx_q.pop_front()) begin $display("FAIL late_req tx: got %b want 1110", tx); bad++; end
    $display("late_req: b granted after %0d wait cycle(s), tx=%b", nwait, tx);
  endtask

  task automatic test_rx();
    logic [1:0] g; logic [3:0] tx; int nvalid, ngrant, nbusy, nwait;
    logic done_seen; logic [3:0] rxd; bit to;
    data_b = 4'h0; req_b = 1'b1;
    exp_rx_q.push_back(4'b1001);
    capture_frame(4'b1001, 1'b0, -1, -1, g, tx, nvalid, ngrant, done_seen, rxd, nbusy, nwait, to);
    total++;
    if (to || done_seen !== 1'b1) begin $display("FAIL rx done: got done=%b to=%0d want 1/0", done_seen, to); bad++; end
    total++;
    if (rxd !== exp_rx_q.pop_front()) begin $display("FAIL rx word: got %b want 1001", rxd); bad++; end
    $display("rx: rx_data at done=%b", rxd);
  endtask

  task automatic test_abort();
    logic [1:0] g; logic [3:0] tx; int nvalid, ngrant, nbusy, nwait;
    logic done_seen; logic [3:0] rxd; bit to;
    data_a = 4'h6; req_a = 1'b1;
    exp_grant_q.push_back(G_A);
    capture_frame(4'b1111, 1'b1, -1, 1, g, tx, nvalid, ngrant, done_seen, rxd, nbusy, nwait, to);
    total++;
    if (to || g !== exp_grant_q.pop_front() || nbusy !== 2 || done_seen !== 1'b0) begin
      $display("FAIL abort shift1: got grant=%b busy=%0d done=%b want 01/2/0", g, nbusy, done_seen); bad++;
    end
    total++;
    if (rx_data !== 4'h9) begin $display("FAIL abort rx_hold: got %h want 9", rx_data); bad++; end
    exp_grant_q.push_back(G_A); exp_tx_q.push_back(4'h6); exp_rx_q.push_back(4'h3);
    capture_frame(4'h3, 1'b0, -1, -1, g, tx, nvalid, ngrant, done_seen, rxd, nbusy, nwait, to);
    total++;
    if (to || nwait !== 1 || g !== exp_grant_q.pop_front()) begin
      $display("FAIL abort pending: got grant=%b wait=%0d want 01/1", g, nwait); bad++;
    end
    total++;
    if (tx !== exp_tx_q.pop_front() || rxd !== exp_rx_q.pop_front()) begin
      $display("FAIL abort refill: got tx=%h rx=%h want 6/3", tx, rxd); bad++;
    end
    $display("abort: aborted after %0d cycles, pending frame tx=%h rx=%h", 2, tx, rxd);
  endtask

  task automatic test_abort_final();
    logic [1:0] g; logic [3:0] tx; int nvalid, ngrant, nbusy, nwait;
    logic done_seen; logic [3:0] rxd; bit to;
    data_a = 4'hC; req_a = 1'b1;
    exp_grant_q.push_back(G_A);
    capture_frame(4'b1111, 1'b0, -1, 3, g, tx, nvalid, ngrant, done_seen, rxd, nbusy, nwait, to);
    total++;
    if (to || g !== exp_grant_q.pop_front() || nbusy !== 4 || done_seen !== 1'b0) begin
      $display("FAIL abort_final: got grant=%b busy=%0d done=%b want 01/4/0", g, nbusy, done_seen); bad++;
    end
    total++;
    if (rx_data !== 4'h3) begin $display("FAIL abort_final rx_hold: got %h want 3", rx_data); bad++; end
    $display("abort_final: busy=%0d done=%b rx_data=%h", nbusy, done_seen, rx_data);
  endtask

  task automatic test_abort_idle();
    logic [1:0] g; logic [3:0] tx; int nvalid, ngrant, nbusy, nwait;
    logic done_seen; logic [3:0] rxd; bit to;
    data_b = 4'h7; req_b = 1'b1; abort = 1'b1;
    exp_grant_q.push_back(G_B); exp_tx_q.push_back(4'h7); exp_rx_q.push_back(4'h5);
    capture_frame(4'h5, 1'b0, -1, -1, g, tx, nvalid, ngrant, done_seen, rxd, nbusy, nwait, to);
    total++;
    if (to || nwait !== 1 || g !== exp_grant_q.pop_front()) begin
      $display("FAIL abort_idle grant: got grant=%b wait=%0d want 10/1", g, nwait); bad++;
    end
    total++;
    if (tx !== exp_tx_q.pop_front() || rxd !== exp_rx_q.pop_front() || done_seen !== 1'b1) begin
      $display("FAIL abort_idle frame: got tx=%h rx=%h done=%b want 7/5/1", tx, rxd, done_seen); bad++;
    end
    $display("abort_idle: grant=%b tx=%h rx=%h", g, tx, rxd);
  endtask

  task automatic test_async_reset();
    logic [1:0] g; logic [3:0] tx; int nvalid, ngrant, nbusy, nwait;
    logic done_seen; logic [3:0] rxd; bit to;
    int guard;
    data_a = 4'hF; req_a = 1'b1;
    guard = 0;
    do begin
      @(negedge clk_2);
      guard++;
    end while (!grant_a && guard < 40);
    total++;
    if (!grant_a) begin $display("FAIL async_reset setup: got no grant_a want grant"); bad++; end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({busy, ser_valid, ser_out, grant_a, grant_b, done, rx_data} !== 10'b0) begin
      $display("FAIL async_reset outputs: got %b want 0", {busy, ser_valid, ser_out, grant_a, grant_b, done, rx_data});
      bad++;
    end
    req_a = 1'b0;
    @(negedge clk_2);
    data_a = 4'h2; data_b = 4'hD; req_a = 1'b1; req_b = 1'b1;
    reset = 1'b0;
    exp_grant_q.push_back(G_A); exp_tx_q.push_back(4'h2);
    capture_frame(4'b0000, 1'b0, -1, -1, g, tx, nvalid, ngrant, done_seen, rxd, nbusy, nwait, to);
    total++;
    if (to || g !== exp_grant_q.pop_front() || tx !== exp_tx_q.pop_front()) begin
      $display("FAIL async_reset tie: got grant=%b tx=%h want 01/2", g, tx); bad++;
    end
    $display("async_reset: outputs cleared, tie after release grant=%b tx=%h", g, tx);
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_round_robin();
    test_late_req();
    test_rx();
    test_abort();
    test_abort_final();
    test_abort_idle();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_arbiter.md
Name: serial_frame_arbiter

Overview:
Round-robin controller that shares one NBITS-wide serial/parallel shift register between two requesters (A, B). A granted requester's word is parallel-loaded, then shifted out LSB-first for NBITS cycles. Bits arriving on ser_in are shifted in at the MSB at the same time, so the block is a full-duplex serial frame engine. It sits between switch/button-driven requesters and the serial pin/LED display path.

Parameters:
NBITS, 4, frame width in bits (shift register width, rx/tx word width); legal range 2..16
CNT_W, $clog2(NBITS), width of the internal bit counter

Ports:
clk_2  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
req_a  input  1  requester A level request
data_a  input  NBITS  word A to transmit, sampled on grant edge
req_b  input  1  requester B level request
data_b  input  NBITS  word B to transmit, sampled on grant edge
abort  input  1  cancel the frame in progress
ser_in  input  1  serial receive bit, sampled every SHIFT edge
ser_out  output  1  serial transmit bit (shreg[0])
ser_valid  output  1  high while ser_out carries a frame bit
grant_a  output  1  one-cycle pulse: A's word was loaded
grant_b  output  1  one-cycle pulse: B's word was loaded
busy  output  1  state != IDLE
done  output  1  one-cycle pulse: frame completed, rx_data valid
rx_data  output  NBITS  last completed received word

Behaviour:
- Reset (async, immediate): state=IDLE, shreg=0, rx_data=0, bit_cnt=0, grant_a=grant_b=0, done=0, last_grant=B (so A wins the first tie); ser_out=0, ser_valid=0, busy=0.
- States: IDLE, SHIFT, DONE.
- IDLE: arbitration happens only here. At an edge with req_a|req_b:
  - winner = sole requester, or, if both request, the one not equal to last_grant.
  - shreg<=winner's data; last_grant<=winner; grant_<winner><=1 for the next cycle only; bit_cnt<=0; state<=SHIFT.
  - No request: hold IDLE.
- SHIFT: ser_valid=1.
  - Each edge: shreg<={ser_in, shreg[NBITS-1:1]}; bit_cnt++.
  - At the edge where bit_cnt==NBITS-1: rx_data<={ser_in, shreg[NBITS-1:1]}; state<=DONE.
  - Transmit bit i appears on ser_out in SHIFT cycle i (i=0..NBITS-1). Receive bit i is sampled at the end of SHIFT cycle i and ends at rx_data[i].
- DONE: done=1 for exactly this cycle; requests ignored; next edge -> IDLE.
- Timing: request seen at edge E0 -> done high in the cycle after edge E0+NBITS. busy is high for NBITS+1 cycles. Back-to-back frames cost NBITS+2 cycles each.
- Requests are levels and are not queued. A request held through the grant pulse is re-served on the next IDLE arbitration. A request raised while busy waits until IDLE.
- abort, sampled in SHIFT or DONE: next state IDLE; no done pulse; rx_data unchanged; shreg keeps its partial value (not observable, since ser_valid=0). abort in IDLE has no effect, and arbitration proceeds normally that edge.
- abort and the final SHIFT edge together: abort wins; rx_data is not updated.
- reset mid-frame: all outputs return to their reset values asynchronously; the frame is lost and last_grant=B.
- grant_* and done are registered outputs; ser_out, ser_valid and busy are decoded from registered state and shreg.

Decomposition:
- Package serial_frame_pkg: typedef enum logic [1:0] {IDLE, SHIFT, DONE} frame_state_t; typedef enum logic {GRANT_A, GRANT_B} grant_t; default NBITS constant.
- Sub-module frame_shreg (ports clk_2, reset, load, shift, din[NBITS], ser_in, q[NBITS]) holds the load/shift register. Load has priority over shift. The arbiter/FSM stays in serial_frame_arbiter.

Test Plan:
- NBITS=4, reset, then req_a=1, data_a=4'b1011, ser_in=0 -> grant_a pulse 1 cycle; ser_out 1,1,0,1 over 4 ser_valid cycles; done 1 cycle; rx_data=4'b0000; busy high 5 cycles.
- Frame with ser_in=1,0,0,1 across SHIFT cycles 0..3 -> rx_data=4'b1001 coincident with the done pulse.
- req_a and req_b both held high from reset, data_a=4'hA, data_b=4'h5 -> grant order A, B, A. Grants 6 cycles apart. Transmitted words 1010, 0101, 1010.
- req_b raised in SHIFT cycle 1 of an A frame -> no grant_b until IDLE; grant_b pulses 1 cycle after the IDLE cycle that follows done.
- abort=1 during SHIFT cycle 1 of a frame (previous rx_data=4'h9) -> IDLE next cycle; no done; rx_data stays 4'h9; a pending req is granted on the following edge.
- reset asserted asynchronously mid-SHIFT (between edges) -> busy, ser_valid, ser_out, grant_*, done and rx_data drop to 0 immediately. After release, a tie grants A first.
